field_lock_clear: RTL and testbench

//  Downstream of the collision check. When the game controller gets a failed down-move check,
//  it pulses start. This block then does two things over several cycles:
//    - Merges the active 4x4 piece into the 20x20 playfield.
//    - Scans the field for full rows, removes them and shifts the rows above down.
//  It returns the new field and the number of lines cleared to the controller.

---
 rtl/tetris_pkg.sv | 52 +++++
 rtl/block_cell_index.sv | 16 +
 rtl/field_lock_clear.sv | 155 +++++++++++++++
 tb/tb_field_lock_clear.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Purpose: shared playfield geometry, FSM encoding, rotation map and line-score table.
// Latency: n/a (types, constants and combinational helper functions only).
// Backpressure: n/a.
// Contents: FIELD_W/FIELD_H/BLK/FIELD_BITS, state_t, rot_index(), score_inc().
package tetris_pkg;

  localparam int FIELD_W    = 20;
  localparam int FIELD_H    = 20;
  localparam int BLK        = 4;
  localparam int FIELD_BITS = FIELD_W * FIELD_H;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MERGE = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_MERGE = ST_MERGE,
    S_SCAN  = ST_SCAN,
    S_DONE  = ST_DONE
  } state_t;

  // Index into the unrotated 4x4 mask for destination cell (bx,by) under rotation rot.
  // All terms stay within 0..15, so 4-bit modular arithmetic never goes negative.
  function automatic logic [3:0] rot_index(input logic [1:0] bx,
                                           input logic [1:0] by,
                                           input logic [1:0] rot);
    logic [3:0] x;
    logic [3:0] y;
    x = {2'b00, bx};
    y = {2'b00, by};
    case (rot)
      2'd0:    rot_index = (y << 2) + x;
      2'd1:    rot_index = 4'd12 + y - (x << 2);
      2'd2:    rot_index = 4'd15 - (y << 2) - x;
      default: rot_index = 4'd3 - y + (x << 2);
    endcase
  endfunction

  // Points awarded for the lines removed by one lock.
  function automatic logic [3:0] score_inc(input logic [2:0] lines);
    case (lines)
      3'd0:    score_inc = 4'd0;
      3'd1:    score_inc = 4'd1;
      3'd2:    score_inc = 4'd3;
      3'd3:    score_inc = 4'd5;
      default: score_inc = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/block_cell_index.sv
// Purpose: maps a destination cell (bx,by) of the rotated piece to its source mask bit.
// Latency: combinational.
// Backpressure: none.
// Ports: bx, by (2b each) cell in bounding box; rot (2b) rotation; idx (4b) mask bit index.
module block_cell_index
  import tetris_pkg::*;
(
  input  logic [1:0] bx,
  input  logic [1:0] by,
  input  logic [1:0] rot,
  output logic [3:0] idx
);

  assign idx = rot_index(bx, by, rot);

endmodule

// File: rtl/field_lock_clear.sv
// Purpose: merges the locked 4x4 piece into the 20x20 field, then removes full rows.
// Latency: accepted start -> done = 1 + 16 + (20 + rows_cleared) + 1 cycles.
// Backpressure: none; start is only sampled in IDLE, starts while busy or in DONE are dropped.
// Ports: clk, rst (async, active-high); start, block, block_pos_x/y, rotate, field_in (request);
//        busy, done, field_out, lines_cleared (result); score only when SCORE_LINES_EN is defined.
module field_lock_clear
  import tetris_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           block,
  input  logic [4:0]            block_pos_x,
  input  logic [4:0]            block_pos_y,
  input  logic [2:0]            rotate,
  input  logic [FIELD_BITS-1:0] field_in,
  output logic                  busy,
  output logic                  done,
  output logic [FIELD_BITS-1:0] field_out,
  output logic [2:0]            lines_cleared
`ifdef SCORE_LINES_EN
  ,
  output logic [15:0]           score
`endif
);

  state_t      state;
  logic [15:0] blk_q;
  logic [4:0]  px_q;
  logic [4:0]  py_q;
  logic [1:0]  rot_q;
  logic [3:0]  i_q;
  logic [4:0]  r_q;

  // Current merge cell within the bounding box.
  logic [1:0]  bx;
  logic [1:0]  by;
  logic [3:0]  src_idx;
  logic        src_bit;
  logic [5:0]  cell_x;
  logic [5:0]  cell_y;
  logic        in_range;
  logic [8:0]  cell_idx;

  assign bx = i_q[1:0];
  assign by = i_q[3:2];

  block_cell_index u_idx (
    .bx  (bx),
    .by  (by),
    .rot (rot_q),
    .idx (src_idx)
  );

  assign src_bit  = blk_q[src_idx];
  // 6-bit sums so a position of 31 plus an offset of 3 lands out of range instead of wrapping.
  assign cell_x   = {1'b0, px_q} + {4'b0000, bx};
  assign cell_y   = {1'b0, py_q} + {4'b0000, by};
  assign in_range = (cell_x < 6'(FIELD_W)) && (cell_y < 6'(FIELD_H));
  assign cell_idx = 9'(cell_y[4:0]) * 9'(FIELD_W) + 9'(cell_x[4:0]);

  // Row scan: is row r full, and what the field looks like with row r removed.
  logic                  row_full;
  logic [FIELD_BITS-1:0] field_shift;

  always_comb begin
    row_full    = &field_out[int'(r_q)*FIELD_W +: FIELD_W];
    field_shift = field_out;
    for (int k = 0; k < FIELD_H; k++) begin
      if (k == 0) begin
        field_shift[0 +: FIELD_W] = '0;
      end else if (k <= int'(r_q)) begin
        field_shift[k*FIELD_W +: FIELD_W] = field_out[(k-1)*FIELD_W +: FIELD_W];
      end
    end
  end

`ifdef SCORE_LINES_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + 17'(score_inc(lines_cleared));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      blk_q         <= '0;
      px_q          <= '0;
      py_q          <= '0;
      rot_q         <= '0;
      i_q           <= '0;
      r_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      field_out     <= '0;
      lines_cleared <= '0;
`ifdef SCORE_LINES_EN
      score         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            blk_q         <= block;
            px_q          <= block_pos_x;
            py_q          <= block_pos_y;
            rot_q         <= 2'(rotate % 3'd4);
            field_out     <= field_in;
            i_q           <= '0;
            lines_cleared <= '0;
            busy          <= 1'b1;
            state         <= S_MERGE;
          end
        end

        S_MERGE: begin
          if (src_bit && in_range) begin
            field_out[cell_idx] <= 1'b1;
          end
          i_q <= i_q + 4'd1;
          if (i_q == 4'd15) begin
            r_q   <= 5'(FIELD_H - 1);
            state <= S_SCAN;
          end
        end

        S_SCAN: begin
          // A cleared row pulls an empty row in at the top, so re-checking the same r
          // always terminates within FIELD_H extra cycles.
          if (row_full) begin
            field_out <= field_shift;
            if (lines_cleared != 3'd7) begin
              lines_cleared <= lines_cleared + 3'd1;
            end
          end else if (r_q == 5'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
`ifdef SCORE_LINES_EN
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
          end else begin
            r_q <= r_q - 5'd1;
          end
        end

        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_field_lock_clear.sv
// Purpose: directed scoreboard bench for field_lock_clear (score checks when SCORE_LINES_EN).
// Latency: expectations carry the absolute cycle in which done must appear.
// Backpressure: n/a.
module tb_field_lock_clear;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  block = '0;
  logic [4:0]   block_pos_x = '0;
  logic [4:0]   block_pos_y = '0;
  logic [2:0]   rotate = '0;
  logic [399:0] field_in = '0;
  logic         busy;
  logic         done;
  logic [399:0] field_out;
  logic [2:0]   lines_cleared;
`ifdef SCORE_LINES_EN
  logic [15:0]  score;
`endif

  field_lock_clear dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .block         (block),
    .block_pos_x   (block_pos_x),
    .block_pos_y   (block_pos_y),
    .rotate        (rotate),
    .field_in      (field_in),
    .busy          (busy),
    .done          (done),
    .field_out     (field_out),
    .lines_cleared (lines_cleared)
`ifdef SCORE_LINES_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [399:0] f;
    logic [2:0]   lines;
    int           cyc;
    logic [15:0]  score;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;
  int   exp_score = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc_cnt++;

  function automatic logic [399:0] with_cell(input logic [399:0] f, input int x, input int y);
    logic [399:0] r;
    r = f;
    r[y*20 + x] = 1'b1;
    return r;
  endfunction

  // Sets row y, except column skip (skip = -1 keeps the row completely full).
  function automatic logic [399:0] with_row(input logic [399:0] f, input int y, input int skip);
    logic [399:0] r;
    r = f;
    for (int x = 0; x < 20; x++) if (x != skip) r[y*20 + x] = 1'b1;
    return r;
  endfunction

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chkf(input string name, input logic [399:0] act, input logic [399:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: field_out differs, got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_chk++;
      if (prev_done) begin
        n_err++;
        $display("FAIL done_width: done high for more than one cycle");
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chkf("mon_field", field_out, e.f);
        chk1("mon_lines", 32'(lines_cleared), 32'(e.lines));
        chk1("mon_latency", 32'(cyc_cnt), 32'(e.cyc));
        chk1("mon_busy_at_done", 32'(busy), 32'd0);
`ifdef SCORE_LINES_EN
        chk1("mon_score", 32'(score), 32'(e.score));
`endif
      end
    end
    prev_done <= done;
  end

  // Issue one request; n is the number of rows the operation clears (drives the latency).
  task automatic launch(input logic [15:0] b, input logic [4:0] x, input logic [4:0] y,
                        input logic [2:0] r, input logic [399:0] fin,
                        input logic [399:0] ef, input logic [2:0] el, input int n,
                        input int sinc, input bit push);
    exp_t e;
    @(negedge clk);
    block = b; block_pos_x = x; block_pos_y = y; rotate = r; field_in = fin; start = 1'b1;
    if (push) begin
      exp_score = exp_score + sinc;
      if (exp_score > 65535) exp_score = 65535;
      e.f = ef; e.lines = el; e.cyc = cyc_cnt + 37 + n; e.score = 16'(exp_score);
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk1("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 150 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: done not seen within 150 cycles", name);
    end
    repeat (2) @(negedge clk);
  endtask

  logic [399:0] fin;
  logic [399:0] ef;

  initial begin
    // Reset state
    #12;
    chk1("rst_busy", 32'(busy), 32'd0);
    chk1("rst_done", 32'(done), 32'd0);
    chkf("rst_field", field_out, '0);
    chk1("rst_lines", 32'(lines_cleared), 32'd0);
`ifdef SCORE_LINES_EN
    chk1("rst_score", 32'(score), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Bottom row completed by the piece and cleared.
    fin = '0;
    for (int x = 4; x < 20; x++) fin = with_cell(fin, x, 19);
    launch(16'h000F, 5'd0, 5'd19, 3'd0, fin, '0, 3'd1, 1, 1, 1'b1);
    wait_done("t1_row_clear");

    // Rotation 1 maps the unrotated top row onto the right-hand column bx=3.
    ef = '0;
    for (int y = 16; y < 20; y++) ef = with_cell(ef, 3, y);
    launch(16'h000F, 5'd0, 5'd16, 3'd1, '0, ef, 3'd0, 0, 0, 1'b1);
    wait_done("t2_rot1");

    // Same piece two rows lower: rows 20 and 21 are dropped, not wrapped.
    ef = '0;
    ef = with_cell(ef, 3, 18);
    ef = with_cell(ef, 3, 19);
    launch(16'h000F, 5'd0, 5'd18, 3'd5, '0, ef, 3'd0, 0, 0, 1'b1);
    wait_done("t2b_drop_bottom");

    // x origin 30: every column is >= 20, nothing merges.
    launch(16'h000F, 5'd30, 5'd0, 3'd0, '0, '0, 3'd0, 0, 0, 1'b1);
    wait_done("t2c_drop_right");

    // Four rows full except column 0; vertical I in column 0 clears all four, marker drops 4.
    fin = '0;
    for (int y = 16; y < 20; y++) fin = with_row(fin, y, 0);
    fin = with_cell(fin, 5, 10);
    ef = with_cell('0, 5, 14);
    launch(16'hF000, 5'd0, 5'd16, 3'd1, fin, ef, 3'd4, 4, 8, 1'b1);
    wait_done("t3_tetris");

    // Extra start pulses during MERGE and SCAN must be ignored.
    fin = with_row('0, 19, -1);
    ef = '0;
    for (int x = 10; x < 14; x++) ef = with_cell(ef, x, 6);
    launch(16'h000F, 5'd10, 5'd5, 3'd0, fin, ef, 3'd1, 1, 1, 1'b1);
    repeat (5) @(negedge clk);
    field_in = with_row('0, 0, -1);
    block = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_ignore_start");
    repeat (3) @(negedge clk);
    chkf("t4_field_hold", field_out, ef);
    chk1("t4_idle_busy", 32'(busy), 32'd0);

    // Eight full rows: lines_cleared saturates at 7.
    fin = '0;
    for (int y = 12; y < 20; y++) fin = with_row(fin, y, -1);
    launch(16'h0000, 5'd0, 5'd0, 3'd0, fin, '0, 3'd7, 8, 8, 1'b1);
    wait_done("t7_saturate");

    // Corner placement, rotation 2, full mask: only the 2x2 in-range corner lands.
    ef = '0;
    ef = with_cell(ef, 18, 18);
    ef = with_cell(ef, 19, 18);
    ef = with_cell(ef, 18, 19);
    ef = with_cell(ef, 19, 19);
    launch(16'hFFFF, 5'd18, 5'd18, 3'd2, '0, ef, 3'd0, 0, 0, 1'b1);
    wait_done("t6_corner");

    // Reset during SCAN: outputs clear at once and no done follows.
    fin = with_row('0, 0, 3);
    launch(16'h000F, 5'd4, 5'd4, 3'd0, fin, '0, 3'd0, 0, 0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("t5_busy", 32'(busy), 32'd0);
    chkf("t5_field", field_out, '0);
    chk1("t5_lines", 32'(lines_cleared), 32'd0);
    chk1("t5_done", 32'(done), 32'd0);
    exp_score = 0;
`ifdef SCORE_LINES_EN
    chk1("t5_score", 32'(score), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);

    // Recovery after the abort.
    launch(16'hFFFF, 5'd18, 5'd18, 3'd2, '0, ef, 3'd0, 0, 0, 1'b1);
    wait_done("t6_after_rst");

    chk1("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
